fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 123 ++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, BOOT/RUN/HALT control FSM and the IF/ID pipeline register.
// Optional static branch/jump prediction is built when FETCH_PREDICT_EN is defined.
module fetch_stage #(
    parameter int                       ADDRESS_WIDTH = 32,
    parameter int                       DATA_WIDTH    = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR  = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     stall_F,
    input  logic                     flush_D,
    input  logic                     pc_src_E,
    input  logic [ADDRESS_WIDTH-1:0] pc_target_E,
    output logic [ADDRESS_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0]    RD,
    output logic [DATA_WIDTH-1:0]    instr_D,
    output logic [ADDRESS_WIDTH-1:0] pc_D,
    output logic [ADDRESS_WIDTH-1:0] pcplus4_D,
    output logic                     valid_D,
    output logic                     halted,
    output logic                     pred_taken_D
);

    localparam logic [DATA_WIDTH-1:0] NOP    = DATA_WIDTH'(32'h0000_0013);
    localparam logic [DATA_WIDTH-1:0] EBREAK = DATA_WIDTH'(32'h0010_0073);

    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

    state_t                   state, state_n;
    logic [ADDRESS_WIDTH-1:0] pc_f, pc_n, pc_plus4, seq_pc;
    logic                     ld, bub;
    logic                     pred_hit;

    assign pc_plus4 = pc_f + ADDRESS_WIDTH'(4);
    assign A        = pc_f;
    assign halted   = (state == HALT);

`ifdef FETCH_PREDICT_EN
    logic                     is_jal, is_bwd_br;
    logic [ADDRESS_WIDTH-1:0] jimm, bimm;

    assign is_jal    = (RD[6:0] == 7'b1101111);
    assign is_bwd_br = (RD[6:0] == 7'b1100011) && RD[31];
    assign jimm      = {{(ADDRESS_WIDTH-20){RD[31]}}, RD[19:12], RD[20], RD[30:21], 1'b0};
    assign bimm      = {{(ADDRESS_WIDTH-12){RD[31]}}, RD[7], RD[30:25], RD[11:8], 1'b0};
    assign pred_hit  = (state == RUN) && (is_jal || is_bwd_br);
    assign seq_pc    = is_jal ? pc_f + jimm : (is_bwd_br ? pc_f + bimm : pc_plus4);
`else
    assign pred_hit  = 1'b0;
    assign seq_pc    = pc_plus4;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= BOOT;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        pc_n    = pc_f;
        ld      = 1'b0;
        bub     = 1'b0;
        case (state)
            BOOT: begin
                bub     = 1'b1;
                state_n = RUN;
            end
            RUN: begin
                if (pc_src_E)     pc_n = pc_target_E;
                else if (!stall_F) pc_n = seq_pc;
                if (flush_D)       bub = 1'b1;
                else if (!stall_F) ld  = 1'b1;
                // a concurrent redirect squashes the halt; the ebreak itself still lands in IF/ID
                if (ld && RD == EBREAK && !pc_src_E) state_n = HALT;
            end
            HALT: begin
                bub = 1'b1;
                if (pc_src_E) begin
                    pc_n    = pc_target_E;
                    state_n = RUN;
                end
            end
            default: begin
                bub     = 1'b1;
                state_n = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_f      <= RESET_VECTOR;
            instr_D   <= NOP;
            pc_D      <= '0;
            pcplus4_D <= '0;
            valid_D   <= 1'b0;
        end else begin
            pc_f <= pc_n;
            if (bub) begin
                instr_D   <= NOP;
                pc_D      <= '0;
                pcplus4_D <= '0;
                valid_D   <= 1'b0;
            end else if (ld) begin
                instr_D   <= RD;
                pc_D      <= pc_f;
                pcplus4_D <= pc_plus4;
                valid_D   <= 1'b1;
            end
        end
    end

`ifdef FETCH_PREDICT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   pred_taken_D <= 1'b0;
        else if (bub) pred_taken_D <= 1'b0;
        else if (ld)  pred_taken_D <= pred_hit && !pc_src_E;
    end
`else
    assign pred_taken_D = 1'b0;
`endif

endmodule
